// File: rtl/rx_axis_tdata_demux.sv
// rx_axis_tdata_demux
// Splits the MAC-side RX AXI-Stream into an RDMA-engine stream (RoCEv2
// frames) and a host/compute stream (everything else). Each frame is
// classified on its first beat and the route is held until tlast. A single
// output register stage feeds both outputs; only the output selected by the
// buffered beat raises tvalid, so frame order on the input is preserved.

module rx_axis_tdata_demux #(
    parameter int PORTS              = 1,
    parameter int AXIS_DATA_WIDTH    = 512 * 2**$clog2(PORTS),
    parameter int AXIS_KEEP_WIDTH    = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_RX_ID_WIDTH   = 10,
    parameter int AXIS_RX_DEST_WIDTH = $clog2(PORTS) + 4,
    parameter int AXIS_RX_USER_WIDTH = 97,
    parameter int STAT_WIDTH         = 32
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          cfg_roce_en,
    input  logic [15:0]                   cfg_udp_port,

    input  logic [AXIS_DATA_WIDTH-1:0]    rx_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]    rx_axis_tkeep,
    input  logic                          rx_axis_tvalid,
    output logic                          rx_axis_tready,
    input  logic                          rx_axis_tlast,
    input  logic [AXIS_RX_ID_WIDTH-1:0]   rx_axis_tid,
    input  logic [AXIS_RX_DEST_WIDTH-1:0] rx_axis_tdest,
    input  logic [AXIS_RX_USER_WIDTH-1:0] rx_axis_tuser,

    output logic [AXIS_DATA_WIDTH-1:0]    re_rx_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]    re_rx_axis_tkeep,
    output logic                          re_rx_axis_tvalid,
    input  logic                          re_rx_axis_tready,
    output logic                          re_rx_axis_tlast,
    output logic [AXIS_RX_ID_WIDTH-1:0]   re_rx_axis_tid,
    output logic [AXIS_RX_DEST_WIDTH-1:0] re_rx_axis_tdest,
    output logic [AXIS_RX_USER_WIDTH-1:0] re_rx_axis_tuser,

    output logic [AXIS_DATA_WIDTH-1:0]    cu_rx_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]    cu_rx_axis_tkeep,
    output logic                          cu_rx_axis_tvalid,
    input  logic                          cu_rx_axis_tready,
    output logic                          cu_rx_axis_tlast,
    output logic [AXIS_RX_ID_WIDTH-1:0]   cu_rx_axis_tid,
    output logic [AXIS_RX_DEST_WIDTH-1:0] cu_rx_axis_tdest,
    output logic [AXIS_RX_USER_WIDTH-1:0] cu_rx_axis_tuser,

    output logic [STAT_WIDTH-1:0]         stat_re_frames,
    output logic [STAT_WIDTH-1:0]         stat_cu_frames
);

    typedef enum logic {ROUTE_CU = 1'b0, ROUTE_RE = 1'b1} route_e;
    typedef enum logic {ST_FIRST = 1'b0, ST_BODY = 1'b1} state_e;

    state_e                         r_state;
    state_e                         w_state_next;
    route_e                         r_route;
    route_e                         w_route_next;
    route_e                         w_first_route;
    route_e                         w_beat_route;

    logic                           r_buf_valid;
    route_e                         r_buf_route;
    logic [AXIS_DATA_WIDTH-1:0]     r_buf_data;
    logic [AXIS_KEEP_WIDTH-1:0]     r_buf_keep;
    logic                           r_buf_last;
    logic [AXIS_RX_ID_WIDTH-1:0]    r_buf_id;
    logic [AXIS_RX_DEST_WIDTH-1:0]  r_buf_dest;
    logic [AXIS_RX_USER_WIDTH-1:0]  r_buf_user;

    logic [STAT_WIDTH-1:0]          r_stat_re;
    logic [STAT_WIDTH-1:0]          r_stat_cu;

    logic [15:0]                    w_ethertype;
    logic [7:0]                     w_ver_ihl;
    logic [7:0]                     w_proto;
    logic [15:0]                    w_dport;
    logic                           w_is_roce;
    logic                           w_sel_ready;
    logic                           w_consume;
    logic                           w_load;

    // Header fields of the beat currently on the input (big-endian, byte i at tdata[8i+:8]).
    assign w_ethertype = {rx_axis_tdata[8*12 +: 8], rx_axis_tdata[8*13 +: 8]};
    assign w_ver_ihl   = rx_axis_tdata[8*14 +: 8];
    assign w_proto     = rx_axis_tdata[8*23 +: 8];
    assign w_dport     = {rx_axis_tdata[8*36 +: 8], rx_axis_tdata[8*37 +: 8]};

    // Only plain IPv4 (no options, no VLAN tag) carrying UDP to the RoCE port qualifies.
    assign w_is_roce = cfg_roce_en
                     & (&rx_axis_tkeep[37:0])
                     & (w_ethertype == 16'h0800)
                     & (w_ver_ihl   == 8'h45)
                     & (w_proto     == 8'h11)
                     & (w_dport     == cfg_udp_port);

    assign w_first_route = w_is_roce ? ROUTE_RE : ROUTE_CU;
    assign w_beat_route  = (r_state == ST_FIRST) ? w_first_route : r_route;

    // tready depends only on registered state and downstream ready, never on tvalid.
    assign w_sel_ready    = (r_buf_route == ROUTE_RE) ? re_rx_axis_tready : cu_rx_axis_tready;
    assign w_consume      = r_buf_valid & w_sel_ready;
    assign rx_axis_tready = ~r_buf_valid | w_sel_ready;
    assign w_load         = rx_axis_tvalid & rx_axis_tready;

    // Frame tracker next state: a first beat latches its classification until tlast.
    always_comb begin
        w_state_next = r_state;
        w_route_next = r_route;
        if (w_load) begin
            w_route_next = w_beat_route;
            w_state_next = rx_axis_tlast ? ST_FIRST : ST_BODY;
        end
    end

    // Frame tracker state and held route.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FIRST;
            r_route <= ROUTE_CU;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers update from pre-edge values.
            r_state <= w_state_next;
            r_route <= w_route_next;
        end
    end

    // Buffer occupancy and the route of the buffered beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf_route <= ROUTE_CU;
        end else if (w_load) begin
            r_buf_valid <= 1'b1;
            r_buf_route <= w_beat_route;
        end else if (w_consume) begin
            r_buf_valid <= 1'b0;
        end
    end

    // Buffered payload and side-band; qualified by r_buf_valid.
    // NOTE: payload registers carry no reset; their value is ignored while r_buf_valid is low.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_buf_data <= rx_axis_tdata;
            r_buf_keep <= rx_axis_tkeep;
            r_buf_last <= rx_axis_tlast;
            r_buf_id   <= rx_axis_tid;
            r_buf_dest <= rx_axis_tdest;
            r_buf_user <= rx_axis_tuser;
        end
    end

    // Per-output frame counters, bumped when a tlast beat leaves; wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_re <= '0;
            r_stat_cu <= '0;
        end else if (w_consume && r_buf_last) begin
            if (r_buf_route == ROUTE_RE) r_stat_re <= r_stat_re + STAT_WIDTH'(1);
            else                         r_stat_cu <= r_stat_cu + STAT_WIDTH'(1);
        end
    end

    assign re_rx_axis_tvalid = r_buf_valid & (r_buf_route == ROUTE_RE);
    assign cu_rx_axis_tvalid = r_buf_valid & (r_buf_route == ROUTE_CU);

    assign re_rx_axis_tdata  = r_buf_data;
    assign re_rx_axis_tkeep  = r_buf_keep;
    assign re_rx_axis_tlast  = r_buf_last;
    assign re_rx_axis_tid    = r_buf_id;
    assign re_rx_axis_tdest  = r_buf_dest;
    assign re_rx_axis_tuser  = r_buf_user;

    assign cu_rx_axis_tdata  = r_buf_data;
    assign cu_rx_axis_tkeep  = r_buf_keep;
    assign cu_rx_axis_tlast  = r_buf_last;
    assign cu_rx_axis_tid    = r_buf_id;
    assign cu_rx_axis_tdest  = r_buf_dest;
    assign cu_rx_axis_tuser  = r_buf_user;

    assign stat_re_frames = r_stat_re;
    assign stat_cu_frames = r_stat_cu;

endmodule

// File: tb/tb_rx_axis_tdata_demux.sv
// Scoreboard bench for rx_axis_tdata_demux: the stimulus side classifies each
// frame from its header bytes and queues the expected beats in input order;
// a monitor pops and compares every beat the DUT hands to either consumer.

module tb_rx_axis_tdata_demux;

    localparam int DW  = 512;
    localparam int KW  = 64;
    localparam int IW  = 10;
    localparam int DSW = 4;
    localparam int UW  = 97;
    localparam int SW  = 32;

    typedef struct {
        bit            to_re;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [IW-1:0] id;
        logic [DSW-1:0] dest;
        logic [UW-1:0] user;
        int            acc;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_roce_en = 1'b1;
    logic [15:0]    cfg_udp_port = 16'd4791;

    logic [DW-1:0]  rx_axis_tdata = '0;
    logic [KW-1:0]  rx_axis_tkeep = '0;
    logic           rx_axis_tvalid = 1'b0;
    logic           rx_axis_tready;
    logic           rx_axis_tlast = 1'b0;
    logic [IW-1:0]  rx_axis_tid = '0;
    logic [DSW-1:0] rx_axis_tdest = '0;
    logic [UW-1:0]  rx_axis_tuser = '0;

    logic [DW-1:0]  re_tdata, cu_tdata;
    logic [KW-1:0]  re_tkeep, cu_tkeep;
    logic           re_tvalid, cu_tvalid;
    logic           re_tready = 1'b1;
    logic           cu_tready = 1'b1;
    logic           re_tlast, cu_tlast;
    logic [IW-1:0]  re_tid, cu_tid;
    logic [DSW-1:0] re_tdest, cu_tdest;
    logic [UW-1:0]  re_tuser, cu_tuser;
    logic [SW-1:0]  stat_re_frames, stat_cu_frames;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    exp_re   = 0;
    int    exp_cu   = 0;
    int    cyc      = 0;
    bit    lat_check = 1'b1;

    rx_axis_tdata_demux dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_roce_en       (cfg_roce_en),
        .cfg_udp_port      (cfg_udp_port),
        .rx_axis_tdata     (rx_axis_tdata),
        .rx_axis_tkeep     (rx_axis_tkeep),
        .rx_axis_tvalid    (rx_axis_tvalid),
        .rx_axis_tready    (rx_axis_tready),
        .rx_axis_tlast     (rx_axis_tlast),
        .rx_axis_tid       (rx_axis_tid),
        .rx_axis_tdest     (rx_axis_tdest),
        .rx_axis_tuser     (rx_axis_tuser),
        .re_rx_axis_tdata  (re_tdata),
        .re_rx_axis_tkeep  (re_tkeep),
        .re_rx_axis_tvalid (re_tvalid),
        .re_rx_axis_tready (re_tready),
        .re_rx_axis_tlast  (re_tlast),
        .re_rx_axis_tid    (re_tid),
        .re_rx_axis_tdest  (re_tdest),
        .re_rx_axis_tuser  (re_tuser),
        .cu_rx_axis_tdata  (cu_tdata),
        .cu_rx_axis_tkeep  (cu_tkeep),
        .cu_rx_axis_tvalid (cu_tvalid),
        .cu_rx_axis_tready (cu_tready),
        .cu_rx_axis_tlast  (cu_tlast),
        .cu_rx_axis_tid    (cu_tid),
        .cu_rx_axis_tdest  (cu_tdest),
        .cu_rx_axis_tuser  (cu_tuser),
        .stat_re_frames    (stat_re_frames),
        .stat_cu_frames    (stat_cu_frames)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_roce(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                   input bit en, input logic [15:0] port);
        logic [7:0] b [64];
        for (int i = 0; i < 64; i++) b[i] = d[8*i +: 8];
        if (!en) return 1'b0;
        for (int i = 0; i < 38; i++) if (k[i] !== 1'b1) return 1'b0;
        return ({b[12], b[13]} == 16'h0800) && (b[14] == 8'h45) &&
               (b[23] == 8'h11) && ({b[36], b[37]} == port);
    endfunction

    function automatic logic [DW-1:0] rand512();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // kind: 0 IPv4/UDP to dport, 1 ARP, 2 VLAN-tagged, 3 IPv4 with options, 4 TCP
    function automatic logic [DW-1:0] make_first(input int kind, input logic [15:0] dport);
        logic [DW-1:0] d;
        logic [15:0]   et;
        d  = rand512();
        et = (kind == 1) ? 16'h0806 : (kind == 2) ? 16'h8100 : 16'h0800;
        d[8*12 +: 8] = et[15:8];
        d[8*13 +: 8] = et[7:0];
        d[8*14 +: 8] = (kind == 3) ? 8'h46 : 8'h45;
        d[8*23 +: 8] = (kind == 4) ? 8'h06 : 8'h11;
        d[8*36 +: 8] = dport[15:8];
        d[8*37 +: 8] = dport[7:0];
        return d;
    endfunction

    // ---------------- driver ----------------
    task automatic drive_beat(input beat_t e);
        bit ok = 1'b0;
        int n  = 0;
        rx_axis_tdata  = e.data;
        rx_axis_tkeep  = e.keep;
        rx_axis_tlast  = e.last;
        rx_axis_tid    = e.id;
        rx_axis_tdest  = e.dest;
        rx_axis_tuser  = e.user;
        rx_axis_tvalid = 1'b1;
        while (!ok && n < 500) begin
            @(negedge clk);
            ok = rx_axis_tready;
            @(posedge clk);
            n++;
        end
        #1;
        rx_axis_tvalid = 1'b0;
        check("input_accept", ok, 1'b1);
        if (ok) begin
            e.acc = cyc;
            sb.push_back(e);
            if (e.last) begin
                if (e.to_re) exp_re++;
                else         exp_cu++;
            end
        end
    endtask

    task automatic send_frame(input int kind, input int nb, input bit short_keep,
                              input logic [15:0] dport, input int chg_beat,
                              input logic [15:0] chg_port);
        beat_t         e;
        logic [DW-1:0] first;
        logic [KW-1:0] fkeep;
        bit            re;
        first = make_first(kind, dport);
        fkeep = short_keep ? 64'h0000_0000_FFFF_FFFF : '1;
        re    = is_roce(first, fkeep, cfg_roce_en, cfg_udp_port);
        for (int b = 0; b < nb; b++) begin
            if (b == chg_beat) cfg_udp_port = chg_port;
            e.to_re = re;
            e.data  = (b == 0) ? first : rand512();
            e.keep  = (b == 0) ? fkeep : '1;
            e.last  = (b == nb - 1);
            e.id    = IW'($urandom);
            e.dest  = DSW'($urandom);
            e.user  = {$urandom, $urandom, $urandom, $urandom};
            e.acc   = 0;
            drive_beat(e);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain_queue_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_stat_re"}, stat_re_frames, exp_re);
        check({tag, "_stat_cu"}, stat_cu_frames, exp_cu);
    endtask

    // ---------------- monitor ----------------
    task automatic pop_cmp(input bit is_re, input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic l, input logic [IW-1:0] id, input logic [DSW-1:0] dst,
                           input logic [UW-1:0] u);
        beat_t e;
        if (sb.size() == 0) begin
            check("unexpected_beat", 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            check("route", is_re, e.to_re);
            check("tdata", d, e.data);
            check("tkeep", k, e.keep);
            check("tlast", l, e.last);
            check("tid",   id, e.id);
            check("tdest", dst, e.dest);
            check("tuser", u, e.user);
            if (lat_check) check("latency", cyc - e.acc, 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (re_tvalid && cu_tvalid) check("one_valid_only", 1'b1, 1'b0);
            if (re_tvalid && re_tready)
                pop_cmp(1'b1, re_tdata, re_tkeep, re_tlast, re_tid, re_tdest, re_tuser);
            if (cu_tvalid && cu_tready)
                pop_cmp(1'b0, cu_tdata, cu_tkeep, cu_tlast, cu_tid, cu_tdest, cu_tuser);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        beat_t         e;
        logic [DW-1:0] first;
        bit            stop;

        #22;
        check("reset_re_tvalid", re_tvalid, 1'b0);
        check("reset_cu_tvalid", cu_tvalid, 1'b0);
        check("reset_stat_re", stat_re_frames, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // 3-beat RoCE frame
        send_frame(0, 3, 1'b0, 16'h12B7, -1, 16'h0);
        wait_drain();
        check_stats("roce3");

        // ARP then UDP/53
        send_frame(1, 2, 1'b0, 16'd4791, -1, 16'h0);
        send_frame(0, 2, 1'b0, 16'd53, -1, 16'h0);
        wait_drain();
        check_stats("arp_dns");

        // RE stalled: RoCE frame then CU frame
        lat_check = 1'b0;
        re_tready = 1'b0;
        fork
            begin
                send_frame(0, 2, 1'b0, 16'd4791, -1, 16'h0);
                send_frame(0, 2, 1'b0, 16'd53, -1, 16'h0);
            end
            begin
                int n = 0;
                while (!re_tvalid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("stall_re_buffered", re_tvalid, 1'b1);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("stall_in_tready", rx_axis_tready, 1'b0);
                    check("stall_cu_idle", cu_tvalid, 1'b0);
                end
                @(posedge clk);
                #1 re_tready = 1'b1;
            end
        join
        wait_drain();
        check_stats("stall");
        lat_check = 1'b1;

        // port changes mid-frame; next frame sees the new port
        send_frame(0, 3, 1'b0, 16'd4791, 1, 16'd1000);
        send_frame(0, 1, 1'b0, 16'd4791, -1, 16'h0);
        cfg_udp_port = 16'd4791;
        wait_drain();
        check_stats("cfg_change");

        // short keep, classify disabled, VLAN, IP options, TCP
        send_frame(0, 1, 1'b1, 16'd4791, -1, 16'h0);
        cfg_roce_en = 1'b0;
        send_frame(0, 2, 1'b0, 16'd4791, -1, 16'h0);
        cfg_roce_en = 1'b1;
        send_frame(2, 1, 1'b0, 16'd4791, -1, 16'h0);
        send_frame(3, 2, 1'b0, 16'd4791, -1, 16'h0);
        send_frame(4, 1, 1'b0, 16'd4791, -1, 16'h0);
        wait_drain();
        check_stats("cu_cases");

        // reset with beat 2 of a 4-beat RoCE frame buffered
        lat_check = 1'b0;
        re_tready = 1'b0;
        first = make_first(0, 16'd4791);
        e.to_re = 1'b1; e.data = first; e.keep = '1; e.last = 1'b0;
        e.id = IW'($urandom); e.dest = DSW'($urandom); e.user = {$urandom, $urandom, $urandom, $urandom};
        drive_beat(e);
        re_tready = 1'b1;
        e.data = rand512();
        drive_beat(e);
        re_tready = 1'b0;
        check("pre_rst_re_tvalid", re_tvalid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_re_tvalid", re_tvalid, 1'b0);
        check("async_rst_cu_tvalid", cu_tvalid, 1'b0);
        check("async_rst_stat_re", stat_re_frames, 0);
        check("async_rst_stat_cu", stat_cu_frames, 0);
        sb.delete();
        exp_re = 0;
        exp_cu = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        re_tready = 1'b1;
        lat_check = 1'b1;
        send_frame(1, 1, 1'b0, 16'd4791, -1, 16'h0);
        send_frame(0, 2, 1'b0, 16'd4791, -1, 16'h0);
        wait_drain();
        check_stats("post_rst");

        // randomized frames with random downstream back-pressure
        lat_check = 1'b0;
        stop = 1'b0;
        fork
            begin
                for (int f = 0; f < 60; f++) begin
                    int kind;
                    kind = ($urandom % 2 == 0) ? 0 : int'($urandom % 5);
                    cfg_roce_en = ($urandom % 8) != 0;
                    send_frame(kind, 1 + int'($urandom % 4), ($urandom % 10) == 0,
                               ($urandom % 4 == 0) ? 16'($urandom) : 16'd4791, -1, 16'h0);
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    re_tready = ($urandom % 4) != 0;
                    cu_tready = ($urandom % 3) != 0;
                end
            end
        join
        re_tready = 1'b1;
        cu_tready = 1'b1;
        wait_drain();
        check_stats("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
